// File: rtl/answer_judge.sv
// Multiplies the latched factor answer and compares the product with the BCD question.
// Optional macro PRIME_CHECK_EN: GOOD also requires every factor to be prime.
module answer_judge #(
  parameter logic [3:0] ST_INPUT = 4'b0100,
  parameter int         W_PROD   = 10,
  parameter logic [1:0] RES_GOOD = 2'b01,
  parameter logic [1:0] RES_OUCH = 2'b10
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [3:0]        STATE,
  input  logic              DEC,
  input  logic              QUE_OK,
  input  logic [11:0]       QUESTION_BCD,
  input  logic [3:0]        COUNT1_OUT,
  input  logic [3:0]        COUNT2_OUT,
  input  logic [3:0]        COUNT3_OUT,
  output logic              BUSY,
  output logic              DONE,
  output logic [1:0]        RESULT,
  output logic [W_PROD-1:0] PRODUCT
);

  typedef enum logic [2:0] {
    S_IDLE, S_CAPT, S_CONV, S_MUL1, S_MUL2, S_CMP, S_HOLD
  } st_t;

  st_t         st;
  logic        dec_q;
  logic [3:0]  a, b, c, cnt;
  logic [11:0] qbcd, q, p, r;
  logic        bad;

  logic        dec_rise, start, abort;
  logic [3:0]  digit;
  logic [11:0] q_nxt;
  logic        nz_ok, prime_ok, good;

  function automatic logic is_prime(input logic [3:0] x);
    return (x == 4'd2) || (x == 4'd3) || (x == 4'd5) || (x == 4'd7);
  endfunction

  assign dec_rise = DEC && !dec_q;
  assign start    = dec_rise && (STATE == ST_INPUT) && QUE_OK;
  assign abort    = (STATE == 4'b0110) || (STATE == 4'b1000) ||
                    (STATE == 4'b1001) || (STATE == 4'b1010) ||
                    (STATE == 4'b1011);

  always_comb begin
    digit = qbcd[3:0];
    unique case (1'b1)
      (cnt == 4'd0): digit = qbcd[11:8];
      (cnt == 4'd1): digit = qbcd[7:4];
      default:       digit = qbcd[3:0];
    endcase
  end

  // x*10 as (x<<3)+(x<<1); first digit loads directly
  assign q_nxt = (cnt == 4'd0) ? {8'd0, digit}
                               : (q << 3) + (q << 1) + {8'd0, digit};

  assign nz_ok = (a != 4'd0) && (b != 4'd0) && (c != 4'd0);
`ifdef PRIME_CHECK_EN
  assign prime_ok = is_prime(a) && is_prime(b) && is_prime(c);
`else
  assign prime_ok = 1'b1;
`endif
  assign good = (r == q) && !bad && nz_ok && prime_ok;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      st      <= S_IDLE;
      dec_q   <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      RESULT  <= 2'b00;
      PRODUCT <= '0;
      a       <= '0;
      b       <= '0;
      c       <= '0;
      cnt     <= '0;
      qbcd    <= '0;
      q       <= '0;
      p       <= '0;
      r       <= '0;
      bad     <= 1'b0;
    end else begin
      dec_q <= DEC;
      DONE  <= 1'b0;
      if (abort) begin
        st     <= S_IDLE;
        RESULT <= 2'b00;
        BUSY   <= 1'b0;
      end else begin
        unique case (st)
          S_IDLE, S_HOLD: begin
            if (start) begin
              st   <= S_CAPT;
              BUSY <= 1'b1;
            end
          end
          S_CAPT: begin
            a      <= COUNT1_OUT;
            b      <= COUNT2_OUT;
            c      <= COUNT3_OUT;
            qbcd   <= QUESTION_BCD;
            RESULT <= 2'b00;
            bad    <= (COUNT1_OUT > 4'd9) || (COUNT2_OUT > 4'd9) ||
                      (COUNT3_OUT > 4'd9);
            cnt    <= '0;
            st     <= S_CONV;
          end
          S_CONV: begin
            q <= q_nxt;
            if (digit > 4'd9) bad <= 1'b1;
            if (cnt == 4'd2) begin
              cnt <= '0;
              st  <= S_MUL1;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          S_MUL1: begin
            p <= (cnt == 4'd0) ? 12'd0 : p + {8'd0, a};
            if (cnt == b) begin
              cnt <= '0;
              st  <= S_MUL2;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          S_MUL2: begin
            r <= (cnt == 4'd0) ? 12'd0 : r + p;
            if (cnt == c) begin
              cnt <= '0;
              st  <= S_CMP;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          S_CMP: begin
            PRODUCT <= r[W_PROD-1:0];
            RESULT  <= good ? RES_GOOD : RES_OUCH;
            DONE    <= 1'b1;
            BUSY    <= 1'b0;
            st      <= S_HOLD;
          end
          default: st <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_answer_judge.sv
// Scoreboard bench for answer_judge: verdict, product and latency per judgement.
// Idle windows confirm ignored starts, aborts and held DEC produce nothing.
module tb_answer_judge;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [3:0]  STATE = 4'b0100;
  logic        DEC = 1'b0;
  logic        QUE_OK = 1'b1;
  logic [11:0] QUESTION_BCD = '0;
  logic [3:0]  COUNT1_OUT = '0;
  logic [3:0]  COUNT2_OUT = '0;
  logic [3:0]  COUNT3_OUT = '0;
  logic        BUSY, DONE;
  logic [1:0]  RESULT;
  logic [9:0]  PRODUCT;

  answer_judge dut (
    .CLK(CLK), .RST(RST), .STATE(STATE), .DEC(DEC), .QUE_OK(QUE_OK),
    .QUESTION_BCD(QUESTION_BCD), .COUNT1_OUT(COUNT1_OUT),
    .COUNT2_OUT(COUNT2_OUT), .COUNT3_OUT(COUNT3_OUT),
    .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .PRODUCT(PRODUCT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int res;
    int prod;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   t0 = 0;
  int   done_cnt = 0;
`ifdef PRIME_CHECK_EN
  int   res_165 = 2;
`else
  int   res_165 = 1;
`endif

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (DONE) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("spurious_done", int'(DONE), 0);
      end else begin
        e = sb.pop_front();
        chk("result", int'(RESULT), e.res);
        chk("product", int'(PRODUCT), e.prod);
        chk("latency", cyc - t0, e.lat);
      end
    end
  end

  task automatic go(input logic [11:0] q, input int a, input int b,
                    input int c, input int res, input int prod,
                    input bit expect_done, input bit hold);
    logic [31:0] av, bv, cv;
    av = a;
    bv = b;
    cv = c;
    @(negedge CLK);
    QUESTION_BCD = q;
    COUNT1_OUT   = av[3:0];
    COUNT2_OUT   = bv[3:0];
    COUNT3_OUT   = cv[3:0];
    DEC          = 1'b1;
    if (expect_done) sb.push_back('{res, prod, 7 + b + c});
    @(posedge CLK);
    #1 t0 = cyc;
    if (!hold) begin
      @(negedge CLK);
      DEC = 1'b0;
    end
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge CLK);
    chk("timeout", sb.size(), 0);
  endtask

  task automatic idle_window(input int n, input string tag);
    int d0;
    int busy_seen;
    d0 = done_cnt;
    busy_seen = 0;
    repeat (n) begin
      @(negedge CLK);
      if (BUSY) busy_seen++;
    end
    chk({tag, "_busy"}, busy_seen, 0);
    chk({tag, "_done"}, done_cnt - d0, 0);
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_result", int'(RESULT), 0);
    chk("rst_done", int'(DONE), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_product", int'(PRODUCT), 0);
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    go(12'h030, 2, 3, 5, 1, 30, 1'b1, 1'b0);
    chk("busy_running", int'(BUSY), 1);
    wait_empty();
    chk("busy_after", int'(BUSY), 0);
    repeat (5) @(negedge CLK);
    chk("result_held", int'(RESULT), 1);

    go(12'h030, 2, 3, 4, 2, 24, 1'b1, 1'b0);
    wait_empty();
    go(12'h030, 0, 3, 5, 2, 0, 1'b1, 1'b0);
    wait_empty();
    go(12'h0A5, 1, 1, 1, 2, 1, 1'b1, 1'b0);
    wait_empty();

    QUE_OK = 1'b0;
    go(12'h030, 2, 3, 5, 0, 0, 1'b0, 1'b0);
    idle_window(25, "que_off");
    chk("que_off_result", int'(RESULT), 2);
    QUE_OK = 1'b1;

    go(12'h648, 8, 9, 9, 1, 648, 1'b1, 1'b0);
    @(negedge CLK);
    STATE = 4'b0101;
    repeat (5) @(negedge CLK);
    STATE = 4'b0100;
    wait_empty();

    go(12'h729, 9, 9, 9, 0, 0, 1'b0, 1'b0);
    repeat (9) @(negedge CLK);
    chk("busy_pre_abort", int'(BUSY), 1);
    STATE = 4'b1001;
    @(negedge CLK);
    STATE = 4'b0100;
    chk("abort_busy", int'(BUSY), 0);
    chk("abort_result", int'(RESULT), 0);
    chk("abort_product", int'(PRODUCT), 648);
    idle_window(40, "abort");

    go(12'h030, 1, 6, 5, res_165, 30, 1'b1, 1'b1);
    wait_empty();
    idle_window(30, "dec_held");
    chk("dec_held_result", int'(RESULT), res_165);
    DEC = 1'b0;
    repeat (3) @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
